// File: rtl/countdown_timer.sv
// Loadable down-counter with pause/abort, one-cycle done pulse and BCD digit outputs.
// Optional feature: define AUTO_RELOAD_EN to restart from the last loaded value after each expiry.
module countdown_timer #(
    parameter int WIDTH        = 7,
    parameter int LOAD_DEFAULT = 5
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             start,
    input  logic             tick,
    input  logic             pause,
    input  logic             abort,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [3:0]       cnt1,
    output logic [3:0]       cnt0,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] LOAD_DEF = WIDTH'(LOAD_DEFAULT);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

    // Tens digit of min(value, 99); the counter is at most 7 bits wide.
    function automatic logic [3:0] bcd_tens(input logic [7:0] value);
        logic [7:0] sat;
        sat = (value > 8'd99) ? 8'd99 : value;
        return 4'(sat / 8'd10);
    endfunction

    // Ones digit of min(value, 99).
    function automatic logic [3:0] bcd_ones(input logic [7:0] value);
        logic [7:0] sat;
        sat = (value > 8'd99) ? 8'd99 : value;
        return 4'(sat % 8'd10);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] start_val_s;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q, reload_d;
`endif

    assign start_val_s = (load_val == ZERO) ? LOAD_DEF : load_val;

    // Next-state and next-count logic; in RUN abort beats pause, which beats tick.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
`ifdef AUTO_RELOAD_EN
        reload_d = reload_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    count_d  = start_val_s;
`ifdef AUTO_RELOAD_EN
                    reload_d = start_val_s;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = LOAD_DEF;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    // Counting at or below one expires rather than wrapping.
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else begin
                        count_d = ZERO;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    count_d = LOAD_DEF;
                end else if (!pause) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
`ifdef AUTO_RELOAD_EN
                state_d = ST_RUN;
                count_d = reload_q;
`else
                state_d = ST_IDLE;
                count_d = LOAD_DEF;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                count_d = LOAD_DEF;
            end
        endcase
    end

    // State, count and reload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            count_q  <= LOAD_DEF;
`ifdef AUTO_RELOAD_EN
            reload_q <= LOAD_DEF;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
`ifdef AUTO_RELOAD_EN
            reload_q <= reload_d;
`endif
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign done  = (state_q == ST_DONE);
    assign cnt1  = bcd_tens(8'(count_q));
    assign cnt0  = bcd_ones(8'(count_q));

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios then random stimulus vs a reference model.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       RESET;
    logic       start, tick, pause, abort;
    logic [6:0] load_val;
    logic [6:0] count;
    logic [3:0] cnt1, cnt0;
    logic       busy, done;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

`ifdef AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int DEF = 5;

    // Reference model: plain flags and an integer count.
    bit m_active  = 1'b0;
    bit m_paused  = 1'b0;
    bit m_expired = 1'b0;
    int m_count   = DEF;
    int m_reload  = DEF;

    countdown_timer #(.WIDTH(7), .LOAD_DEFAULT(DEF)) dut (
        .clk(clk), .RESET(RESET), .start(start), .tick(tick), .pause(pause),
        .abort(abort), .load_val(load_val), .count(count), .cnt1(cnt1),
        .cnt0(cnt0), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
        end
    endtask

    task automatic model_clk(input bit s, input bit t, input bit p, input bit a,
                             input int lv, input bit r);
        if (!r) begin
            m_active = 0; m_paused = 0; m_expired = 0; m_count = DEF;
        end else if (m_expired) begin
            m_expired = 0;
            if (AUTO) begin m_active = 1; m_count = m_reload; end
            else begin m_active = 0; m_count = DEF; end
        end else if (!m_active) begin
            if (s) begin
                m_count  = (lv == 0) ? DEF : lv;
                m_reload = m_count;
                m_active = 1; m_paused = 0;
            end
        end else if (a) begin
            m_active = 0; m_paused = 0; m_count = DEF;
        end else if (m_paused) begin
            if (!p) m_paused = 0;
        end else if (p) begin
            m_paused = 1;
        end else if (t) begin
            m_count = m_count - 1;
            if (m_count <= 0) begin
                m_count = 0; m_active = 0; m_expired = 1;
            end
        end
    endtask

    task automatic check_all();
        int v;
        v = (m_count > 99) ? 99 : m_count;
        chk("count", 32'(count), 32'(m_count));
        chk("cnt1",  32'(cnt1),  32'(v / 10));
        chk("cnt0",  32'(cnt0),  32'(v % 10));
        chk("busy",  32'(busy),  32'(m_active));
        chk("done",  32'(done),  32'(m_expired));
    endtask

    task automatic step(input bit s, input bit t, input bit p, input bit a,
                        input int lv, input bit r);
        @(negedge clk);
        start = s; tick = t; pause = p; abort = a; load_val = 7'(lv); RESET = r;
        @(posedge clk);
        model_clk(s, t, p, a, lv, r);
        step_no++;
        #1;
        check_all();
    endtask

    initial begin
        start = 1'b0; tick = 1'b0; pause = 1'b0; abort = 1'b0;
        load_val = 7'd0; RESET = 1'b0;

        // Reset held two cycles
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 9, 0);
        chk("rst_count", 32'(count), 32'd5);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);

        // Load 3, three ticks, expiry then back to idle
        step(1, 0, 0, 0, 3, 1);
        chk("load3", 32'(count), 32'd3);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("expire_done", 32'(done), 32'd1);
        chk("expire_cnt",  32'(count), 32'd0);
        step(0, 1, 0, 0, 0, 1);

        // load_val 0 picks default; paused ticks dropped, tick on release ignored
        step(1, 0, 0, 0, 0, 1);
        chk("load0", 32'(count), 32'd5);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 1);
        chk("paused_hold", 32'(count), 32'd5);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 7, 1);

        // BCD of 42, then abort beats tick
        if (AUTO) step(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 42, 1);
        chk("bcd_tens", 32'(cnt1), 32'd4);
        chk("bcd_ones", 32'(cnt0), 32'd2);
        step(0, 1, 0, 1, 0, 1);
        chk("abort_cnt",  32'(count), 32'd5);
        chk("abort_done", 32'(done),  32'd0);

        // Reset mid-run at count 2 with a tick in the same cycle
        step(1, 0, 0, 0, 3, 1);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        chk("midrst_cnt",  32'(count), 32'd5);
        chk("midrst_busy", 32'(busy),  32'd0);

        // Saturating BCD and start ignored while running
        step(1, 0, 0, 0, 120, 1);
        step(1, 1, 0, 0, 9, 1);
        step(0, 0, 0, 1, 0, 1);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 25), ($urandom_range(0, 99) < 55),
                 ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 4),
                 (($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6))),
                 ($urandom_range(0, 99) >= 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
